wb_copy_dma: RTL and testbench

- Single-channel Wishbone classic-cycle master that copies a block of 32-bit words from a source region to a destination region.
- Drives one port (A or B) of the dual-port RAM directly; the other port stays free for a CPU or test master.
- Configured by a start pulse carrying source, destination and length; reports busy, done, error and progress.
- One word is in flight at a time: read it, then write it.

---
 rtl/wb_copy_dma_if.sv | 16 +
 rtl/wb_copy_dma.sv | 135 +++++++++++++
 tb/tb_wb_copy_dma.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wb_copy_dma_if.sv
// wb_copy_dma_if: Wishbone classic-cycle bus between the copy DMA master and a memory port
interface wb_copy_dma_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_w;
    logic [31:0]       dat_r;
    logic              we;
    logic              stb;
    logic              cyc;
    logic              ack;
    logic              stall;

    modport master(output adr, dat_w, we, stb, cyc, input dat_r, ack, stall);
    modport slave (input adr, dat_w, we, stb, cyc, output dat_r, ack, stall);
endinterface

// File: rtl/wb_copy_dma.sv
// wb_copy_dma: single-channel Wishbone master copying a block of words, one read then one write per word
module wb_copy_dma #(
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [LEN_W-1:0]    words_done_o,
    wb_copy_dma_if.master       wb
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_src, r_dst, r_adr;
    logic [LEN_W-1:0]  r_rem, r_words;
    logic [TW-1:0]     r_tmo;
    logic [31:0]       r_wdat;
    logic              r_busy, r_done, r_err, r_cyc, r_stb, r_we;
    logic              w_expire;

    assign w_expire = r_tmo == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_adr   <= '0;
            r_rem   <= '0;
            r_words <= '0;
            r_tmo   <= '0;
            r_wdat  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start_i) begin
                    r_src   <= src_addr_i & ALIGN;
                    r_dst   <= dst_addr_i & ALIGN;
                    r_rem   <= len_i;
                    r_words <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_tmo   <= '0;
                    if (len_i == '0) r_state <= DONE;
                    else begin
                        r_state <= RD;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= src_addr_i & ALIGN;
                    end
                end
                RD: if (wb.ack) begin
                    r_wdat  <= wb.dat_r;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_state <= RD_GAP;
                end else if (w_expire) begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else r_tmo <= r_tmo + 1'b1;
                RD_GAP: begin
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_adr   <= r_dst;
                    r_tmo   <= '0;
                    r_state <= WR;
                end
                // Ack arriving on the expiry cycle still completes the word
                WR: if (wb.ack) begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_words <= r_words + 1'b1;
                    r_state <= WR_GAP;
                end else if (w_expire) begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else r_tmo <= r_tmo + 1'b1;
                WR_GAP: begin
                    r_src <= r_src + ADDR_W'(4);
                    r_dst <= r_dst + ADDR_W'(4);
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == LEN_W'(1)) r_state <= DONE;
                    else begin
                        r_state <= RD;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_adr   <= r_src + ADDR_W'(4);
                        r_tmo   <= '0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign words_done_o = r_words;
    assign wb.adr       = r_adr;
    assign wb.dat_w     = r_wdat;
    assign wb.we        = r_we;
    assign wb.stb       = r_stb;
    assign wb.cyc       = r_cyc;
endmodule

// File: tb/tb_wb_copy_dma.sv
// tb_wb_copy_dma: table-driven bench with a 4 KiB single-cycle-ack memory slave and a side write port
module tb_wb_copy_dma;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [15:0] wd;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        ack = 1'b0, no_ack = 1'b0, pb_init = 1'b0, pb_we = 1'b0;
    logic [31:0] rdat = '0, pb_addr = '0, pb_data = '0;
    int          stall_cfg = 0, stall_left = 0;
    int          tests = 0, fails = 0;

    wb_copy_dma_if #(.ADDR_W(32)) wb();

    wb_copy_dma #(.ADDR_W(32), .LEN_W(16), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
        .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .words_done_o(wd), .wb(wb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int k);
        return (k < 4) ? 32'h1111_1111 * (k + 1) : {16'hC0DE, 16'(k)};
    endfunction

    assign wb.stall = stall_left != 0;
    assign wb.ack   = ack;
    assign wb.dat_r = rdat;

    always @(posedge clk) begin
        if (pb_init) for (int k = 0; k < 1024; k++) mem[k] <= init_val(k);
        if (pb_we) mem[pb_addr[11:2]] <= pb_data;
        if (start) stall_left <= stall_cfg;
        else if (wb.cyc && wb.stb && stall_left != 0) stall_left <= stall_left - 1;
        if (rst) ack <= 1'b0;
        else if (wb.cyc && wb.stb && !ack && !wb.stall && !no_ack) begin
            ack <= 1'b1;
            if (wb.we) mem[wb.adr[11:2]] <= wb.dat_w;
            else rdat <= mem[wb.adr[11:2]];
        end else ack <= 1'b0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) ref_mem[((d >> 2) + i) % 1024] = ref_mem[((s >> 2) + i) % 1024];
    endtask

    task automatic chk_mem(input string nm);
        int bad = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) bad++;
        chk(nm, 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [31:0] s, d;
        logic [15:0] l;
        int          stall;
        logic        noack, pb;
        int          ra;
        logic [15:0] e_wd;
        logic        e_err;
        int          e_busy, e_cyc;
    } vec_t;

    task automatic run_copy(input vec_t v, output int busy_n, output int cyc_n, output bit done_ok);
        @(negedge clk);
        src = v.s; dst = v.d; len = v.l; stall_cfg = v.stall; no_ack = v.noack;
        pb_we = v.pb; pb_addr = 32'h010; pb_data = 32'hBEEF_0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; pb_we = 1'b0;
        busy_n = 0; cyc_n = 0; done_ok = 0;
        for (int k = 0; k < 3000 && !done_ok; k++) begin
            busy_n += int'(busy);
            cyc_n  += int'(wb.cyc);
            done_ok = done;
            start = (k == v.ra);
            if (k == v.ra) begin src = 32'h100; dst = 32'h900; len = 16'd7; end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    vec_t vecs [9];
    int   bn, cn;
    bit   dn, early_done;

    initial begin
        vecs[0] = '{32'h000,      32'h400, 16'd4, 0,  1'b0, 1'b0, -1, 16'd4, 1'b0, 25, 16};
        vecs[1] = '{32'h000,      32'h200, 16'd0, 0,  1'b0, 1'b0, -1, 16'd0, 1'b0, 1,  0};
        vecs[2] = '{32'h013,      32'h302, 16'd3, 0,  1'b0, 1'b0, -1, 16'd3, 1'b0, 19, 12};
        vecs[3] = '{32'h000,      32'h004, 16'd3, 0,  1'b0, 1'b0, -1, 16'd3, 1'b0, 19, 12};
        vecs[4] = '{32'hFFFFFFFC, 32'h500, 16'd2, 0,  1'b0, 1'b0, -1, 16'd2, 1'b0, 13, 8};
        vecs[5] = '{32'h008,      32'h00C, 16'd1, 5,  1'b0, 1'b1, -1, 16'd1, 1'b0, 12, 9};
        vecs[6] = '{32'h008,      32'h010, 16'd1, 18, 1'b0, 1'b0, -1, 16'd1, 1'b0, 25, 22};
        vecs[7] = '{32'h020,      32'h600, 16'd1, 19, 1'b0, 1'b0, -1, 16'd0, 1'b1, 21, 20};
        vecs[8] = '{32'h040,      32'h800, 16'd4, 0,  1'b0, 1'b0, 3,  16'd4, 1'b0, 25, 16};
        for (int k = 0; k < 1024; k++) ref_mem[k] = init_val(k);
        pb_init = 1'b1;
        repeat (2) @(negedge clk);
        pb_init = 1'b0;
        chk("reset_state", {busy, done, err, wb.cyc, wb.stb, wb.we, wd, wb.adr, wb.dat_w}, 64'd0);
        rst = 1'b0;
        chk_mem("preload");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pb) ref_mem[4] = 32'hBEEF_0010;
            run_copy(vecs[i], bn, cn, dn);
            ref_copy(vecs[i].s & ~32'd3, vecs[i].d & ~32'd3, int'(vecs[i].e_wd));
            chk($sformatf("v%0d_done", i), 64'(dn), 64'd1);
            chk($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
            chk($sformatf("v%0d_words", i), 64'(wd), 64'(vecs[i].e_wd));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bn), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d_cyc_cycles", i), 64'(cn), 64'(vecs[i].e_cyc));
            chk_mem($sformatf("v%0d_mem", i));
        end

        run_copy('{32'h000, 32'h700, 16'd2, 0, 1'b1, 1'b0, -1, 16'd0, 1'b1, 21, 20}, bn, cn, dn);
        chk("noack_err", 64'(err), 64'd1);
        chk("noack_cyc_cycles", 64'(cn), 64'd20);
        chk("noack_words", 64'(wd), 64'd0);
        chk("noack_done", 64'(dn), 64'd1);
        no_ack = 1'b0; stall_cfg = 0;
        @(negedge clk);
        src = 32'h000; dst = 32'h700; len = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared_on_start", 64'(err), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        ref_copy(32'h000, 32'h700, 2);
        chk("recover_words", 64'(wd), 64'd2);
        chk_mem("recover_mem");

        @(negedge clk);
        src = 32'h080; dst = 32'hA00; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        early_done = 1'b0;
        for (int k = 0; k < 100 && !(wb.we && wb.stb && wd == 16'd1); k++) begin
            early_done |= done;
            @(negedge clk);
        end
        chk("reached_wr2", 64'({wb.we, wb.stb, wd}), 64'({1'b1, 1'b1, 16'd1}));
        rst = 1'b1;
        #1;
        chk("rst_drops_bus", 64'({wb.cyc, wb.stb, busy}), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            early_done |= done;
        end
        chk("rst_no_done", 64'(early_done), 64'd0);
        rst = 1'b0;
        ref_copy(32'h080, 32'hA00, 1);
        chk_mem("rst_partial_mem");
        run_copy('{32'h080, 32'hA00, 16'd4, 0, 1'b0, 1'b0, -1, 16'd4, 1'b0, 25, 16}, bn, cn, dn);
        ref_copy(32'h080, 32'hA00, 4);
        chk("post_rst_words", 64'(wd), 64'd4);
        chk("post_rst_busy_cycles", 64'(bn), 64'd25);
        chk_mem("post_rst_mem");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
